// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the IF stage of the 5-stage MIPS pipeline.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int unsigned PC_INC   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/program_counter.sv
// PC register: word-aligned redirect load, or increment from a caller-supplied base.
module program_counter
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       PWIDTH   = 32,
    parameter logic [PWIDTH-1:0] RESET_PC = '0
) (
    input  logic              f_clk,
    input  logic              f_rst,
    input  logic              redirect,
    input  logic [PWIDTH-1:0] target,
    input  logic              advance,
    input  logic [PWIDTH-1:0] base,
    output logic [PWIDTH-1:0] pc,
    output logic [PWIDTH-1:0] pc_next
);

    logic [PWIDTH-1:0] pc_reg;

    // Redirect wins; targets are forced onto a word boundary.
    always_comb begin
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = target & ~PWIDTH'(3);
        end else if (advance) begin
            pc_next = base + PWIDTH'(PC_INC);
        end
    end

    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: req/ack instruction fetch with a one-entry skid, redirect squash and IF/ID output registers.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       PWIDTH   = 32,
    parameter int unsigned       IWIDTH   = 32,
    parameter logic [PWIDTH-1:0] RESET_PC = '0
) (
    input  logic              f_clk,
    input  logic              f_rst,
    input  logic              f_i_stall,
    input  logic              f_i_flush,
    input  logic              f_i_change_pc,
    input  logic [PWIDTH-1:0] f_i_alu_pc,
    output logic              f_o_imem_req,
    output logic [PWIDTH-1:0] f_o_imem_addr,
    input  logic              f_i_imem_ack,
    input  logic [IWIDTH-1:0] f_i_imem_data,
    output logic [IWIDTH-1:0] f_o_instr,
    output logic [PWIDTH-1:0] f_o_pc,
    output logic              f_o_ce
);

    localparam logic [IWIDTH-1:0] NOP = IWIDTH'(NOP_WORD);

    fetch_state_e      state_reg, state_next;
    logic              req_reg, req_next;
    logic [PWIDTH-1:0] addr_reg, addr_next;
    logic              squash_reg, squash_next;
    logic [IWIDTH-1:0] skid_instr_reg, skid_instr_next;
    logic [PWIDTH-1:0] skid_pc_reg, skid_pc_next;
    logic [IWIDTH-1:0] out_instr_reg, out_instr_next;
    logic [PWIDTH-1:0] out_pc_reg, out_pc_next;
    logic              out_ce_reg, out_ce_next;

    logic              pc_advance;
    logic [PWIDTH-1:0] pc_base;
    logic [PWIDTH-1:0] pc_cur;
    logic [PWIDTH-1:0] pc_next;
    logic              slot_held;

    program_counter #(
        .PWIDTH   (PWIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .f_clk    (f_clk),
        .f_rst    (f_rst),
        .redirect (f_i_change_pc),
        .target   (f_i_alu_pc),
        .advance  (pc_advance),
        .base     (pc_base),
        .pc       (pc_cur),
        .pc_next  (pc_next)
    );

    // A valid output survives the cycle only while decode stalls on it.
    assign slot_held = out_ce_reg && f_i_stall && !f_i_flush;

    always_comb begin
        state_next      = state_reg;
        req_next        = req_reg;
        addr_next       = addr_reg;
        squash_next     = squash_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;
        out_ce_next     = slot_held;
        out_instr_next  = slot_held ? out_instr_reg : NOP;
        out_pc_next     = out_pc_reg;
        pc_advance      = 1'b0;
        pc_base         = addr_reg;

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
                req_next   = 1'b1;
                addr_next  = pc_next;
            end
            ST_FETCH: begin
                if (f_i_imem_ack) begin
                    if (f_i_change_pc || squash_reg) begin
                        // Wrong-path word: drop it and restart at the (possibly new) target.
                        squash_next = 1'b0;
                        addr_next   = pc_next;
                    end else if (!slot_held) begin
                        pc_advance = 1'b1;
                        addr_next  = pc_next;
                        // During a flush the returning word is consumed but not presented.
                        if (!f_i_flush) begin
                            out_instr_next = f_i_imem_data;
                            out_pc_next    = addr_reg;
                            out_ce_next    = 1'b1;
                        end
                    end else begin
                        skid_instr_next = f_i_imem_data;
                        skid_pc_next    = addr_reg;
                        req_next        = 1'b0;
                        state_next      = ST_HOLD;
                    end
                end else if (f_i_change_pc) begin
                    squash_next = 1'b1;
                end
            end
            ST_HOLD: begin
                if (f_i_change_pc) begin
                    state_next = ST_FETCH;
                    req_next   = 1'b1;
                    addr_next  = pc_next;
                end else if (!f_i_flush && !slot_held) begin
                    out_instr_next = skid_instr_reg;
                    out_pc_next    = skid_pc_reg;
                    out_ce_next    = 1'b1;
                    pc_advance     = 1'b1;
                    pc_base        = skid_pc_reg;
                    addr_next      = pc_next;
                    req_next       = 1'b1;
                    state_next     = ST_FETCH;
                end
            end
            default: begin
                state_next = ST_IDLE;
                req_next   = 1'b0;
            end
        endcase

        if (f_i_change_pc || f_i_flush) begin
            out_ce_next    = 1'b0;
            out_instr_next = NOP;
        end
    end

    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            state_reg      <= ST_IDLE;
            req_reg        <= 1'b0;
            addr_reg       <= RESET_PC;
            squash_reg     <= 1'b0;
            skid_instr_reg <= NOP;
            skid_pc_reg    <= '0;
            out_instr_reg  <= NOP;
            out_pc_reg     <= '0;
            out_ce_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            req_reg        <= req_next;
            addr_reg       <= addr_next;
            squash_reg     <= squash_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
            out_instr_reg  <= out_instr_next;
            out_pc_reg     <= out_pc_next;
            out_ce_reg     <= out_ce_next;
        end
    end

    assign f_o_imem_req  = req_reg;
    assign f_o_imem_addr = addr_reg;
    assign f_o_instr     = out_instr_reg;
    assign f_o_pc        = out_pc_reg;
    assign f_o_ce        = out_ce_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage; memory returns the inverted address as the instruction.
module tb_fetch_stage;

    logic        f_clk;
    logic        f_rst;
    logic        f_i_stall;
    logic        f_i_flush;
    logic        f_i_change_pc;
    logic [31:0] f_i_alu_pc;
    logic        f_o_imem_req;
    logic [31:0] f_o_imem_addr;
    logic        f_i_imem_ack;
    logic [31:0] f_i_imem_data;
    logic [31:0] f_o_instr;
    logic [31:0] f_o_pc;
    logic        f_o_ce;

    int checks = 0;
    int errors = 0;

    fetch_stage #(
        .PWIDTH   (32),
        .IWIDTH   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .f_clk         (f_clk),
        .f_rst         (f_rst),
        .f_i_stall     (f_i_stall),
        .f_i_flush     (f_i_flush),
        .f_i_change_pc (f_i_change_pc),
        .f_i_alu_pc    (f_i_alu_pc),
        .f_o_imem_req  (f_o_imem_req),
        .f_o_imem_addr (f_o_imem_addr),
        .f_i_imem_ack  (f_i_imem_ack),
        .f_i_imem_data (f_i_imem_data),
        .f_o_instr     (f_o_instr),
        .f_o_pc        (f_o_pc),
        .f_o_ce        (f_o_ce)
    );

    initial f_clk = 1'b0;
    always #5 f_clk = ~f_clk;

    assign f_i_imem_data = ~f_o_imem_addr;

    // Each record: outputs expected at this negedge, then inputs driven for the coming posedge.
    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        chg;
        logic [31:0] alu;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ce;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic check32(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic e_req, input logic [31:0] e_addr,
                                 input logic e_ce, input logic [31:0] e_pc);
        logic [31:0] e_instr;
        e_instr = e_ce ? ~e_pc : 32'h0;
        check32("req", idx, {31'b0, f_o_imem_req}, {31'b0, e_req});
        check32("addr", idx, f_o_imem_addr, e_addr);
        check32("ce", idx, {31'b0, f_o_ce}, {31'b0, e_ce});
        check32("pc", idx, f_o_pc, e_pc);
        check32("instr", idx, f_o_instr, e_instr);
        $display("step %0d: req=%0b addr=%h ce=%0b pc=%h instr=%h", idx,
                 f_o_imem_req, f_o_imem_addr, f_o_ce, f_o_pc, f_o_instr);
    endtask

    initial begin
        //                   stall flush chg  alu            ack   req  addr           ce   pc
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0008});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_0008});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_000C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_000C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0014, 1'b1, 32'h0000_0010});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h40,       1'b0, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_0010});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_0010});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_0010});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_0010});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0044, 1'b1, 32'h0000_0040});
        vecs.push_back(vec_t'{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0048, 1'b1, 32'h0000_0044});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_004C, 1'b0, 32'h0000_0044});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h43,       1'b1, 1'b1, 32'h0000_0050, 1'b1, 32'h0000_004C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0000_0040, 1'b0, 32'h0000_004C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_004C});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 32'h80,       1'b0, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0004});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h100,      1'b0, 1'b1, 32'h0000_0080, 1'b0, 32'h0000_0004});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 32'h200,      1'b0, 1'b1, 32'h0000_0080, 1'b0, 32'h0000_0004});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0080, 1'b0, 32'h0000_0004});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0004});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0204, 1'b1, 32'h0000_0200});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0000_0204, 1'b0, 32'h0000_0200});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000_0208, 1'b1, 32'h0000_0204});

        f_rst         = 1'b0;
        f_i_stall     = 1'b0;
        f_i_flush     = 1'b0;
        f_i_change_pc = 1'b0;
        f_i_alu_pc    = 32'h0;
        f_i_imem_ack  = 1'b0;

        repeat (2) @(negedge f_clk);
        check_outputs(-1, 1'b0, 32'h0, 1'b0, 32'h0);
        f_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            check_outputs(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_ce, vecs[i].e_pc);
            f_i_stall     = vecs[i].stall;
            f_i_flush     = vecs[i].flush;
            f_i_change_pc = vecs[i].chg;
            f_i_alu_pc    = vecs[i].alu;
            f_i_imem_ack  = vecs[i].ack;
            @(negedge f_clk);
        end

        // Reset mid-request: req and ce must drop without waiting for a clock edge.
        f_i_stall    = 1'b0;
        f_i_imem_ack = 1'b0;
        check_outputs(100, 1'b1, 32'h0000_0208, 1'b0, 32'h0000_0204);
        #2 f_rst = 1'b0;
        #1 check_outputs(101, 1'b0, 32'h0, 1'b0, 32'h0);

        // Late ack arriving during IDLE must be ignored.
        @(negedge f_clk);
        f_rst        = 1'b1;
        f_i_imem_ack = 1'b1;
        @(negedge f_clk);
        check_outputs(102, 1'b1, 32'h0000_0000, 1'b0, 32'h0);
        @(negedge f_clk);
        check_outputs(103, 1'b1, 32'h0000_0004, 1'b1, 32'h0000_0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
